regfile_mp: RTL and testbench
=============================

# regfile_mp

Parametrised multi-port general-purpose register file for the core: NR combinational read ports with write-to-read bypass, NW write ports with fixed priority, a per-register busy scoreboard for in-flight producers, and a req/ack debug (JTAG) access port arbitrated against core writes with a bounded-wait pipeline hold. Sits between id (reads, allocation) and ex/wb (writes), and replaces the two-read/one-write file.

## Interface
- DW, 32, data width
- AW, 5, address width; depth = 2**AW, register 0 hardwired to zero
- NR, 2, number of read ports
- NW, 2, number of write ports; higher index has higher priority
- DBG_WAIT, 8, cycles a debug request may wait before hold_o asserts (>=1)

Ports. Single clock; reset asynchronous, active-low.
- clk  in  1  clock
- rst  in  1  asynchronous active-low reset
- we_i  in  NW  per-port write enable
- waddr_i  in  NW*AW  write addresses, port k at [k*AW +: AW]
- wdata_i  in  NW*DW  write data, port k at [k*DW +: DW]
- raddr_i  in  NR*AW  read addresses
- rdata_o  out  NR*DW  read data (combinational)
- busy_o  out  NR  read register has outstanding producer (combinational)
- alloc_i  in  1  mark alloc_addr_i busy
- alloc_addr_i  in  AW  destination being allocated
- dbg_req_i  in  1  debug request, held until dbg_ack_o
- dbg_we_i  in  1  1 = write, 0 = read
- dbg_addr_i  in  AW  debug address
- dbg_wdata_i  in  DW  debug write data
- dbg_ack_o  out  1  one-cycle completion pulse (registered)
- dbg_rdata_o  out  DW  debug read data (registered, valid with ack, held after)
- hold_o  out  1  asks pipeline to suppress all we_i (registered)

## Operation
- Storage: 2**AW x DW flops; reset clears every entry to 0.
- Writes: at posedge, port k with we_i[k] and waddr!=0 writes. Same address on several ports: highest-index port wins. Writes to 0 ignored.
- Reads: raddr==0 -> 0. Else highest-index port k with we_i[k] && waddr_k==raddr forwards wdata_k; else stored value. Debug write data is never forwarded.
- Scoreboard: one busy bit per register, bit 0 constant 0. Posedge: write clears bit of its address; alloc_i sets bit of alloc_addr_i (nonzero only). Alloc and write to same address same cycle: bit ends set (new producer wins).
- busy_o[i] = sb[raddr_i] && no active write port to raddr_i this cycle (value forwarded); 0 for address 0.
- Debug FSM, states IDLE, PEND, ACK:
  - IDLE: dbg_req_i && no we_i bit set -> access this edge, go ACK. dbg_req_i with any we_i -> PEND, wait counter = 1.
  - PEND: no we_i -> access this edge, go ACK, clear counter/hold. Else counter++; hold_o registered 1 when counter reaches DBG_WAIT, held until access.
  - ACK: dbg_ack_o = 1 for exactly this cycle; return to IDLE unconditionally; dbg_req_i here ignored (requester drops req on ack).
  - Access: write -> regs[dbg_addr_i] <= dbg_wdata_i (ignored for 0); read -> dbg_rdata_o <= stored value (0 for address 0). Debug write does not touch scoreboard.
  - dbg_req_i deasserted in PEND -> IDLE, no access, no ack, hold cleared.
- Core writes always win over debug; debug never blocks a core write.

## Timing
- Reset values: all regs 0, scoreboard 0, FSM IDLE, dbg_ack_o 0, dbg_rdata_o 0, hold_o 0. Reset mid-PEND/ACK aborts silently, no ack.
- Read/busy: zero-cycle, combinational from raddr_i, we_i, waddr_i, wdata_i.
- Write visible in array the cycle after its edge; bypass covers the write cycle.
- Debug latency, idle core: req at cycle n -> access at edge ending n -> ack in n+1. Each cycle with a core write adds one.
- hold_o rises DBG_WAIT cycles after entering PEND; falls the cycle after access.

## Test plan
- Reset then read all 32 addresses on both ports -> all 0, busy_o=0, dbg_ack_o=0, hold_o=0.
- we_i=2'b11, both waddr=5, wdata 0xAAAA/0x5555; raddr0=5 same cycle -> rdata 0x5555; next cycle stored 0x5555. Write to x0 -> reads 0.
- alloc x7; next cycle busy_o=1 for raddr=7; write x7=0x12 -> busy_o=0 that cycle, rdata=0x12; alloc x7 + write x7 same cycle -> busy stays 1.
- Debug write x3=0xDEADBEEF, core idle -> ack one cycle later; debug read x3 -> dbg_rdata_o=0xDEADBEEF with ack; read x0 -> 0, ack given.
- Debug req with we_i held active 10 cycles, DBG_WAIT=8 -> hold_o high after 8 PEND cycles; drop we_i -> access, ack next cycle, hold_o low after.
- Assert rst low while in PEND with hold_o=1 -> hold_o, ack 0 immediately; FSM IDLE; contents 0.

Source files
------------

// File: rtl/regfile_mp.sv
// Multi-port register file: combinational bypassed reads, prioritised writes,
// per-register busy scoreboard and a req/ack debug port with bounded-wait hold.
module regfile_mp #(
    parameter int DW       = 32,
    parameter int AW       = 5,
    parameter int NR       = 2,
    parameter int NW       = 2,
    parameter int DBG_WAIT = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [NW-1:0]    we_i,
    input  logic [NW*AW-1:0] waddr_i,
    input  logic [NW*DW-1:0] wdata_i,
    input  logic [NR*AW-1:0] raddr_i,
    output logic [NR*DW-1:0] rdata_o,
    output logic [NR-1:0]    busy_o,
    input  logic             alloc_i,
    input  logic [AW-1:0]    alloc_addr_i,
    input  logic             dbg_req_i,
    input  logic             dbg_we_i,
    input  logic [AW-1:0]    dbg_addr_i,
    input  logic [DW-1:0]    dbg_wdata_i,
    output logic             dbg_ack_o,
    output logic [DW-1:0]    dbg_rdata_o,
    output logic             hold_o,
    output logic [1:0]       dbg_state_o
);

    localparam int DEPTH = 1 << AW;
    localparam int CW    = $clog2(DBG_WAIT + 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PEND = 2'd1,
        ST_ACK  = 2'd2
    } dbg_state_e;

    logic [DW-1:0] regs_q [DEPTH];
    logic [DW-1:0] regs_d [DEPTH];
    logic [DEPTH-1:0] sb_q, sb_d;

    dbg_state_e    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          hold_q, hold_d;
    logic          ack_q, ack_d;
    logic [DW-1:0] dbg_rdata_q, dbg_rdata_d;

    logic core_wr;
    logic dbg_access;

    assign core_wr = |we_i;

    // Debug FSM: state register plus its registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            hold_q      <= 1'b0;
            ack_q       <= 1'b0;
            dbg_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            hold_q      <= hold_d;
            ack_q       <= ack_d;
            dbg_rdata_q <= dbg_rdata_d;
        end
    end

    // Debug FSM: next state. The wait counter saturates at DBG_WAIT.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        hold_d  = hold_q;
        case (state_q)
            ST_IDLE: begin
                if (dbg_req_i) begin
                    if (core_wr) begin
                        state_d = ST_PEND;
                        cnt_d   = CW'(1);
                    end else begin
                        state_d = ST_ACK;
                    end
                end
            end
            ST_PEND: begin
                if (!dbg_req_i || !core_wr) begin
                    state_d = dbg_req_i ? ST_ACK : ST_IDLE;
                    cnt_d   = '0;
                    hold_d  = 1'b0;
                end else begin
                    if (cnt_q >= CW'(DBG_WAIT)) hold_d = 1'b1;
                    else                        cnt_d  = cnt_q + CW'(1);
                end
            end
            ST_ACK:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Debug FSM: outputs. Access only happens on an edge with no core write.
    always_comb begin
        dbg_access  = dbg_req_i && !core_wr && (state_q == ST_IDLE || state_q == ST_PEND);
        ack_d       = dbg_access;
        dbg_rdata_d = dbg_rdata_q;
        if (dbg_access && !dbg_we_i) begin
            dbg_rdata_d = (dbg_addr_i == '0) ? '0 : regs_q[dbg_addr_i];
        end
    end

    assign dbg_ack_o   = ack_q;
    assign dbg_rdata_o = dbg_rdata_q;
    assign hold_o      = hold_q;
    assign dbg_state_o = state_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            regs_q <= '{default: '0};
            sb_q   <= '0;
        end else begin
            regs_q <= regs_d;
            sb_q   <= sb_d;
        end
    end

    // Later ports overwrite earlier ones, giving the highest index priority.
    always_comb begin
        regs_d = regs_q;
        sb_d   = sb_q;
        if (dbg_access && dbg_we_i && dbg_addr_i != '0) begin
            regs_d[dbg_addr_i] = dbg_wdata_i;
        end
        for (int k = 0; k < NW; k++) begin
            if (we_i[k] && waddr_i[k*AW +: AW] != '0) begin
                regs_d[waddr_i[k*AW +: AW]] = wdata_i[k*DW +: DW];
                sb_d[waddr_i[k*AW +: AW]]   = 1'b0;
            end
        end
        // A new producer allocated on the same edge outranks the retiring one.
        if (alloc_i && alloc_addr_i != '0) sb_d[alloc_addr_i] = 1'b1;
        sb_d[0] = 1'b0;
    end

    always_comb begin : read_ports
        logic [AW-1:0] ra;
        logic [DW-1:0] rd;
        logic          hit;
        rdata_o = '0;
        busy_o  = '0;
        ra      = '0;
        rd      = '0;
        hit     = 1'b0;
        for (int i = 0; i < NR; i++) begin
            ra  = raddr_i[i*AW +: AW];
            rd  = regs_q[ra];
            hit = 1'b0;
            for (int k = 0; k < NW; k++) begin
                if (we_i[k] && waddr_i[k*AW +: AW] == ra) begin
                    rd  = wdata_i[k*DW +: DW];
                    hit = 1'b1;
                end
            end
            if (ra == '0) rd = '0;
            rdata_o[i*DW +: DW] = rd;
            busy_o[i]           = (ra != '0) && sb_q[ra] && !hit;
        end
    end

endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench for regfile_mp: reset state, bypass, scoreboard and debug port.
module tb_regfile_mp;

    localparam int DW = 32;
    localparam int AW = 5;
    localparam int NR = 2;
    localparam int NW = 2;
    localparam int DBG_WAIT = 8;

    logic             clk = 1'b0;
    logic             rst;
    logic [NW-1:0]    we_i;
    logic [NW*AW-1:0] waddr_i;
    logic [NW*DW-1:0] wdata_i;
    logic [NR*AW-1:0] raddr_i;
    logic [NR*DW-1:0] rdata_o;
    logic [NR-1:0]    busy_o;
    logic             alloc_i;
    logic [AW-1:0]    alloc_addr_i;
    logic             dbg_req_i;
    logic             dbg_we_i;
    logic [AW-1:0]    dbg_addr_i;
    logic [DW-1:0]    dbg_wdata_i;
    logic             dbg_ack_o;
    logic [DW-1:0]    dbg_rdata_o;
    logic             hold_o;
    logic [1:0]       dbg_state_o;

    int errors = 0;
    int checks = 0;

    regfile_mp #(.DW(DW), .AW(AW), .NR(NR), .NW(NW), .DBG_WAIT(DBG_WAIT)) dut (
        .clk(clk), .rst(rst), .we_i(we_i), .waddr_i(waddr_i), .wdata_i(wdata_i),
        .raddr_i(raddr_i), .rdata_o(rdata_o), .busy_o(busy_o),
        .alloc_i(alloc_i), .alloc_addr_i(alloc_addr_i),
        .dbg_req_i(dbg_req_i), .dbg_we_i(dbg_we_i), .dbg_addr_i(dbg_addr_i),
        .dbg_wdata_i(dbg_wdata_i), .dbg_ack_o(dbg_ack_o), .dbg_rdata_o(dbg_rdata_o),
        .hold_o(hold_o), .dbg_state_o(dbg_state_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic core_wr(input logic [1:0] we, input logic [AW-1:0] a0, input logic [DW-1:0] d0,
                           input logic [AW-1:0] a1, input logic [DW-1:0] d1);
        we_i    = we;
        waddr_i = {a1, a0};
        wdata_i = {d1, d0};
    endtask

    task automatic rd(input logic [AW-1:0] a0, input logic [AW-1:0] a1);
        raddr_i = {a1, a0};
        #1;
    endtask

    task automatic dbg(input logic req, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
        dbg_req_i   = req;
        dbg_we_i    = we;
        dbg_addr_i  = a;
        dbg_wdata_i = d;
    endtask

    initial begin
        rst = 1'b0;
        core_wr(2'b00, 0, 0, 0, 0);
        raddr_i = '0;
        alloc_i = 1'b0;
        alloc_addr_i = '0;
        dbg(1'b0, 1'b0, 0, 0);
        repeat (3) tick();
        rst = 1'b1;
        tick();

        // Reset state on every address, both ports.
        for (int a = 0; a < 32; a++) begin
            rd(AW'(a), AW'(31 - a));
            chk("rst_rdata0", rdata_o[DW-1:0], 32'h0);
            chk("rst_rdata1", rdata_o[2*DW-1:DW], 32'h0);
            chk("rst_busy", {30'h0, busy_o}, 32'h0);
        end
        chk("rst_ack", {31'h0, dbg_ack_o}, 32'h0);
        chk("rst_hold", {31'h0, hold_o}, 32'h0);
        chk("rst_state", {30'h0, dbg_state_o}, 32'h0);
        chk("rst_dbg_rdata", dbg_rdata_o, 32'h0);

        // Same-address dual write: port 1 wins, bypassed in the write cycle.
        core_wr(2'b11, 5, 32'hAAAA, 5, 32'h5555);
        rd(5, 0);
        chk("bypass_prio", rdata_o[DW-1:0], 32'h5555);
        chk("bypass_x0", rdata_o[2*DW-1:DW], 32'h0);
        tick();
        core_wr(2'b00, 0, 0, 0, 0);
        rd(5, 5);
        chk("stored_prio0", rdata_o[DW-1:0], 32'h5555);
        chk("stored_prio1", rdata_o[2*DW-1:DW], 32'h5555);

        // Write to x0 is neither forwarded nor stored.
        core_wr(2'b01, 0, 32'hFFFF, 0, 0);
        rd(0, 0);
        chk("x0_bypass", rdata_o[DW-1:0], 32'h0);
        tick();
        core_wr(2'b00, 0, 0, 0, 0);
        rd(0, 0);
        chk("x0_stored", rdata_o[DW-1:0], 32'h0);

        // Independent addresses on both ports in one cycle.
        core_wr(2'b11, 6, 32'h66, 9, 32'h99);
        tick();
        core_wr(2'b00, 0, 0, 0, 0);
        rd(6, 9);
        chk("dual_wr6", rdata_o[DW-1:0], 32'h66);
        chk("dual_wr9", rdata_o[2*DW-1:DW], 32'h99);

        // Scoreboard: allocate x7, then retire, then alloc+write together.
        alloc_i = 1'b1; alloc_addr_i = 7;
        rd(7, 0);
        chk("alloc_same_cycle", {30'h0, busy_o}, 32'h0);
        tick();
        alloc_i = 1'b0;
        rd(7, 0);
        chk("busy_set", {30'h0, busy_o}, 32'h1);
        core_wr(2'b01, 7, 32'h12, 0, 0);
        rd(7, 7);
        chk("busy_fwd", {30'h0, busy_o}, 32'h0);
        chk("fwd_x7", rdata_o[DW-1:0], 32'h12);
        tick();
        core_wr(2'b00, 0, 0, 0, 0);
        rd(7, 0);
        chk("busy_cleared", {30'h0, busy_o}, 32'h0);
        chk("stored_x7", rdata_o[DW-1:0], 32'h12);
        alloc_i = 1'b1; alloc_addr_i = 7;
        core_wr(2'b10, 0, 0, 7, 32'h34);
        tick();
        alloc_i = 1'b0;
        core_wr(2'b00, 0, 0, 0, 0);
        rd(7, 7);
        chk("alloc_wins", {30'h0, busy_o}, 32'h3);
        chk("stored_x7b", rdata_o[DW-1:0], 32'h34);
        alloc_i = 1'b1; alloc_addr_i = 0;
        tick();
        alloc_i = 1'b0;
        rd(0, 7);
        chk("alloc_x0", {30'h0, busy_o}, 32'h2);

        // Debug write, idle core: ack the next cycle.
        dbg(1'b1, 1'b1, 3, 32'hDEADBEEF);
        #1;
        chk("dw_ack_early", {31'h0, dbg_ack_o}, 32'h0);
        tick();
        dbg(1'b0, 1'b0, 0, 0);
        rd(3, 0);
        chk("dw_ack", {31'h0, dbg_ack_o}, 32'h1);
        chk("dw_state_ack", {30'h0, dbg_state_o}, 32'h2);
        chk("dw_stored", rdata_o[DW-1:0], 32'hDEADBEEF);
        chk("dw_no_busy", {30'h0, busy_o}, 32'h0);
        tick();
        chk("dw_ack_pulse", {31'h0, dbg_ack_o}, 32'h0);
        chk("dw_state_idle", {30'h0, dbg_state_o}, 32'h0);

        // Debug read x3, data held after ack.
        dbg(1'b1, 1'b0, 3, 0);
        tick();
        dbg(1'b0, 1'b0, 0, 0);
        #1;
        chk("dr_ack", {31'h0, dbg_ack_o}, 32'h1);
        chk("dr_rdata", dbg_rdata_o, 32'hDEADBEEF);
        tick();
        chk("dr_ack_off", {31'h0, dbg_ack_o}, 32'h0);
        chk("dr_rdata_held", dbg_rdata_o, 32'hDEADBEEF);

        // Debug read x0 returns zero and is still acked.
        dbg(1'b1, 1'b0, 0, 0);
        tick();
        dbg(1'b0, 1'b0, 0, 0);
        #1;
        chk("dr0_ack", {31'h0, dbg_ack_o}, 32'h1);
        chk("dr0_rdata", dbg_rdata_o, 32'h0);
        tick();

        // Request dropped in PEND: no access, no ack.
        dbg(1'b1, 1'b1, 4, 32'hBAD);
        core_wr(2'b01, 8, 32'h1, 0, 0);
        tick();
        #1;
        chk("drop_pend", {30'h0, dbg_state_o}, 32'h1);
        dbg(1'b0, 1'b0, 0, 0);
        core_wr(2'b00, 0, 0, 0, 0);
        tick();
        rd(4, 0);
        chk("drop_idle", {30'h0, dbg_state_o}, 32'h0);
        chk("drop_no_ack", {31'h0, dbg_ack_o}, 32'h0);
        chk("drop_no_wr", rdata_o[DW-1:0], 32'h0);

        // Bounded wait: core writes for 10 cycles, hold rises after 8 PEND cycles.
        dbg(1'b1, 1'b1, 4, 32'h44);
        for (int j = 0; j < 10; j++) begin
            core_wr(2'b01, 8, DW'(j), 0, 0);
            #1;
            chk("wait_hold", {31'h0, hold_o}, {31'h0, (j >= 9)});
            chk("wait_ack", {31'h0, dbg_ack_o}, 32'h0);
            tick();
        end
        core_wr(2'b00, 0, 0, 0, 0);
        #1;
        chk("wait_hold_kept", {31'h0, hold_o}, 32'h1);
        chk("wait_state_pend", {30'h0, dbg_state_o}, 32'h1);
        tick();
        dbg(1'b0, 1'b0, 0, 0);
        rd(4, 8);
        chk("wait_ack_late", {31'h0, dbg_ack_o}, 32'h1);
        chk("wait_hold_low", {31'h0, hold_o}, 32'h0);
        chk("wait_dbg_wr", rdata_o[DW-1:0], 32'h44);
        chk("wait_core_wr", rdata_o[2*DW-1:DW], 32'h9);
        tick();
        chk("wait_ack_off", {31'h0, dbg_ack_o}, 32'h0);

        // Reset while PEND with hold high aborts silently.
        dbg(1'b1, 1'b0, 3, 0);
        core_wr(2'b01, 8, 32'h77, 0, 0);
        repeat (10) tick();
        chk("pre_rst_hold", {31'h0, hold_o}, 32'h1);
        rst = 1'b0;
        core_wr(2'b00, 0, 0, 0, 0);
        dbg(1'b0, 1'b0, 0, 0);
        rd(3, 5);
        chk("rst_mid_hold", {31'h0, hold_o}, 32'h0);
        chk("rst_mid_ack", {31'h0, dbg_ack_o}, 32'h0);
        chk("rst_mid_state", {30'h0, dbg_state_o}, 32'h0);
        chk("rst_mid_x3", rdata_o[DW-1:0], 32'h0);
        chk("rst_mid_x5", rdata_o[2*DW-1:DW], 32'h0);
        rd(7, 0);
        chk("rst_mid_busy", {30'h0, busy_o}, 32'h0);
        tick();
        rst = 1'b1;
        tick();
        chk("post_rst_ack", {31'h0, dbg_ack_o}, 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
